// File: rtl/freq_gen.sv
// Phase-accumulator square-wave generator with burst length, stop and saturating pulse counter.
// Define FREQ_GEN_CARRIER_EN to AND the output with a free-running 38 kHz carrier for IR drive.
module freq_gen #(
    parameter int unsigned WINDOW_CYCLES = 1000000,
    parameter int unsigned BURST_W       = 16
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic [31:0]        freq_in,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               load,
    input  logic               stop,
    output logic               signal_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BURST_W-1:0] pulse_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [32:0]        WIN  = 33'(WINDOW_CYCLES);
    localparam logic [32:0]        HALF = 33'(WINDOW_CYCLES / 2);
    localparam logic [BURST_W-1:0] ONE  = BURST_W'(1);

    state_t             state_q, state_d;
    logic [31:0]        freq_q, freq_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [31:0]        acc_q, acc_d;
    logic               wave_q, wave_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic [BURST_W-1:0] fall_q, fall_d;
    logic [32:0]        sum, diff;
    logic               wrap, freq_ok;

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        burst_d = burst_q;
        acc_d   = acc_q;
        wave_d  = wave_q;
        pulse_d = pulse_q;
        fall_d  = fall_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        sum     = {1'b0, acc_q} + {freq_q, 1'b0};
        diff    = sum - WIN;
        wrap    = (sum >= WIN);
        freq_ok = (freq_in != 32'd0) && ({1'b0, freq_in} < HALF);

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (freq_ok) begin
                        freq_d  = freq_in;
                        burst_d = burst_len;
                        acc_d   = '0;
                        wave_d  = 1'b0;
                        pulse_d = '0;
                        fall_d  = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // stop wins over the burst-final toggle, so done can only pulse once
                if (stop) begin
                    wave_d  = 1'b0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    acc_d = wrap ? diff[31:0] : sum[31:0];
                    if (wrap) begin
                        wave_d = ~wave_q;
                        if (!wave_q) begin
                            if (pulse_q != '1)
                                pulse_d = pulse_q + ONE;
                        end else begin
                            fall_d = fall_q + ONE;
                            if ((burst_q != '0) && (fall_q == burst_q - ONE)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            freq_q  <= '0;
            burst_q <= '0;
            acc_q   <= '0;
            wave_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pulse_q <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            burst_q <= burst_d;
            acc_q   <= acc_d;
            wave_q  <= wave_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            fall_q  <= fall_d;
        end
    end

`ifdef FREQ_GEN_CARRIER_EN
    logic [10:0] car_cnt_q, car_cnt_d;
    logic        carrier_q, carrier_d;

    always_comb begin
        car_cnt_d = car_cnt_q + 11'd1;
        carrier_d = carrier_q;
        if (car_cnt_q == 11'd1315) begin
            car_cnt_d = '0;
            carrier_d = ~carrier_q;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            car_cnt_q <= '0;
            carrier_q <= 1'b0;
        end else begin
            car_cnt_q <= car_cnt_d;
            carrier_q <= carrier_d;
        end
    end

    assign signal_out = wave_q & carrier_q;
`else
    assign signal_out = wave_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pulse_count = pulse_q;

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen with a 10000-cycle window: vector table with scoreboard plus reset/stop sequences.
module tb_freq_gen;

    localparam int unsigned W = 10000;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] freq_in   = '0;
    logic [15:0] burst_len = '0;
    logic        load      = 1'b0;
    logic        stop      = 1'b0;
    logic        signal_out, busy, done, err;
    logic [15:0] pulse_count;

    freq_gen #(.WINDOW_CYCLES(W), .BURST_W(16)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .freq_in    (freq_in),
        .burst_len  (burst_len),
        .load       (load),
        .stop       (stop),
        .signal_out (signal_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pulse_count(pulse_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        int freq; int burst; int stop_at; int reload_at; int ld_stop; int limit;
        int errs; int first; int rises; int done_at; int dones; int pcount;
    } vec_t;

    typedef struct {
        int errs; int first; int rises; int done_at; int dones; int pcount;
    } res_t;

    vec_t tbl[12];
    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input int f, input int b, input int sa, input int ra, input int ls,
                                input int lim, input int e, input int fi, input int r,
                                input int da, input int dn, input int pc);
        vec_t v;
        v.freq = f; v.burst = b; v.stop_at = sa; v.reload_at = ra; v.ld_stop = ls; v.limit = lim;
        v.errs = e; v.first = fi; v.rises = r; v.done_at = da; v.dones = dn; v.pcount = pc;
        return v;
    endfunction

    // Drives one load, watches outputs for v.limit cycles, then scores against the queued expectation.
    task automatic run_vec(input int idx, input vec_t v);
        res_t e, got;
        logic prev;
        int   busy_end, sig_end;
        @(negedge CLK100MHZ);
        freq_in   = v.freq;
        burst_len = 16'(v.burst);
        load      = 1'b1;
        stop      = 1'(v.ld_stop);
        e.errs = v.errs; e.first = v.first; e.rises = v.rises;
        e.done_at = v.done_at; e.dones = v.dones; e.pcount = v.pcount;
        exp_q.push_back(e);
        @(posedge CLK100MHZ);
        #1;
        load = 1'b0;
        stop = 1'b0;
        got = '{0, 0, 0, 0, 0, 0};
        prev = 1'b0;
        for (int n = 0; n <= v.limit; n++) begin
            @(negedge CLK100MHZ);
            if (signal_out && !prev) begin
                got.rises++;
                if (got.first == 0) got.first = n;
            end
            prev = signal_out;
            if (done) begin
                got.dones++;
                got.done_at = n;
            end
            if (err) got.errs++;
            stop = (n + 1 == v.stop_at);
            if (n + 1 == v.reload_at) begin
                load = 1'b1; freq_in = 32'd4999; burst_len = 16'd5;
            end else begin
                load = 1'b0;
            end
        end
        stop = 1'b0;
        load = 1'b0;
        got.pcount = int'(pulse_count);
        busy_end   = int'(busy);
        sig_end    = int'(signal_out);
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d_queue_empty", idx), 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_err", idx),     got.errs,    e.errs);
            chk($sformatf("v%0d_first", idx),   got.first,   e.first);
            chk($sformatf("v%0d_rises", idx),   got.rises,   e.rises);
            chk($sformatf("v%0d_done_at", idx), got.done_at, e.done_at);
            chk($sformatf("v%0d_dones", idx),   got.dones,   e.dones);
            chk($sformatf("v%0d_pcount", idx),  got.pcount,  e.pcount);
            chk($sformatf("v%0d_busy_end", idx), busy_end, 0);
            chk($sformatf("v%0d_sig_end", idx),  sig_end,  0);
        end
    endtask

    initial begin
        int cnt;
        //            freq  burst stop  rel ls  limit  err first rises done  dones pc
        tbl[0]  = mk(10,    0, 10001,  0, 0, 10003, 0,  500,  10, 10001, 1, 10);
        tbl[1]  = mk(10,    3,     0,  0, 0,  3100, 0,  500,   3,  3000, 1,  3);
        tbl[2]  = mk(25,    2,     0,  0, 0,   900, 0,  200,   2,   800, 1,  2);
        tbl[3]  = mk(0,     1,     0,  0, 0,    50, 1,    0,   0,     0, 0,  2);
        tbl[4]  = mk(5000,  1,     0,  0, 0,    50, 1,    0,   0,     0, 0,  2);
        tbl[5]  = mk(4999,  1,     0,  0, 0,    50, 0,    2,   1,     3, 1,  1);
        tbl[6]  = mk(3,     1,     0,  0, 0,  3400, 0, 1667,   1,  3334, 1,  1);
        tbl[7]  = mk(20,   10,  1300,  0, 0,  1400, 0,  250,   3,  1300, 1,  3);
        tbl[8]  = mk(10,    1,  1000,  0, 0,  1100, 0,  500,   1,  1000, 1,  1);
        tbl[9]  = mk(10,    1,     0, 100, 0, 1100, 0,  500,   1,  1000, 1,  1);
        tbl[10] = mk(25,    2,     0,  0, 1,   900, 0,  200,   2,   800, 1,  2);
        tbl[11] = mk(4999,  1,     0,  0, 1,    50, 0,    2,   1,     3, 1,  1);

        #23;
        chk("rst_sig",    int'(signal_out),  0);
        chk("rst_busy",   int'(busy),        0);
        chk("rst_done",   int'(done),        0);
        chk("rst_err",    int'(err),         0);
        chk("rst_pcount", int'(pulse_count), 0);
        @(negedge CLK100MHZ);
        reset = 1'b0;

        // stop while idle must do nothing
        cnt = 0;
        stop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK100MHZ);
            if (done || busy || signal_out) cnt++;
        end
        stop = 1'b0;
        chk("idle_stop_activity", cnt, 0);

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // reset during a high phase: outputs drop at once, no done, no restart
        @(negedge CLK100MHZ);
        freq_in = 32'd10; burst_len = 16'd3; load = 1'b1;
        @(negedge CLK100MHZ);
        load = 1'b0;
        for (int i = 0; i < 600; i++) @(negedge CLK100MHZ);
        chk("mid_sig_high", int'(signal_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_sig",  int'(signal_out), 0);
        chk("async_rst_busy", int'(busy),       0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            if (done) cnt++;
        end
        reset = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK100MHZ);
            if (done || signal_out || busy) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        chk("post_rst_pcount", int'(pulse_count), 0);
        run_vec(100, tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
